// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto one
// shared single-ported RAM with a 1-cycle synchronous read.
// Optional feature: define MEM_ARBITER_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin (default build uses fixed data-over-fetch priority).
//
// Handshake: a requester raises *_req with its address/data stable and holds it
// until it sees its one-cycle *_ack; once an access reaches ACCESS it always
// completes and acks, even if the request drops; reset aborts it with no ack.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    output logic [15:0] conflict_cnt,
    output logic [1:0]  o_state
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_grant_d;      // 1 = data port owns the current access
    logic        r_store;        // current access is a data store
    logic        r_if_ack;
    logic        r_d_ack;
    logic        r_ram_we;
    logic [15:0] r_ram_addr;
    logic [15:0] r_ram_wdata;
    logic [15:0] r_if_rdata;
    logic [15:0] r_d_rdata;
    logic [15:0] r_conflict_cnt;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic        r_last_d;       // 1 = most recent grant went to data
`endif

    logic        w_both;
    logic        w_pick_d;
    logic        w_other_req;
    logic        w_start;
    logic        w_start_d;

    // Both ports pending at an IDLE decision is a conflict.
    assign w_both = if_req & d_req;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    assign w_pick_d = w_both ? ~r_last_d : d_req;
`else
    assign w_pick_d = d_req;
`endif

    // In RESP the port being acked is ignored; only the other port can chain.
    assign w_other_req = r_grant_d ? if_req : d_req;

    assign w_start   = ((r_state == ST_IDLE) && (if_req || d_req)) ||
                       ((r_state == ST_RESP) && w_other_req);
    assign w_start_d = (r_state == ST_IDLE) ? w_pick_d : ~r_grant_d;

    // Access FSM, RAM control, acks, read-data holding and conflict counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_grant_d      <= 1'b1;
            r_store        <= 1'b0;
            r_if_ack       <= 1'b0;
            r_d_ack        <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_addr     <= 16'h0000;
            r_ram_wdata    <= 16'h0000;
            r_if_rdata     <= 16'h0000;
            r_d_rdata      <= 16'h0000;
            r_conflict_cnt <= 16'h0000;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            r_last_d       <= 1'b1;
`endif
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_both && (r_conflict_cnt != 16'hFFFF))
                        r_conflict_cnt <= r_conflict_cnt + 16'd1;
                end
                ST_ACCESS: begin
                    r_state  <= ST_RESP;
                    r_ram_we <= 1'b0;
                    if (r_grant_d) r_d_ack  <= 1'b1;
                    else           r_if_ack <= 1'b1;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    // Latch the read data so the port keeps it until its next read.
                    if (!r_grant_d)    r_if_rdata <= ram_rdata;
                    else if (!r_store) r_d_rdata  <= ram_rdata;
                end
                default: r_state <= ST_IDLE;
            endcase
            // A new grant overrides the default next state above.
            if (w_start) begin
                r_state    <= ST_ACCESS;
                r_grant_d  <= w_start_d;
                r_store    <= w_start_d & d_we;
                r_ram_we   <= w_start_d & d_we;
                r_ram_addr <= w_start_d ? d_addr : if_addr;
                if (w_start_d && d_we) r_ram_wdata <= d_wdata;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                r_last_d   <= w_start_d;
`endif
            end
        end
    end

    // RAM data lands during RESP; expose it immediately, then hold the latched copy.
    assign if_rdata     = ((r_state == ST_RESP) && !r_grant_d) ? ram_rdata : r_if_rdata;
    assign d_rdata      = ((r_state == ST_RESP) && r_grant_d && !r_store) ? ram_rdata : r_d_rdata;
    assign if_ack       = r_if_ack;
    assign d_ack        = r_d_ack;
    assign if_stall     = if_req & ~r_if_ack;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
    assign ram_we       = r_ram_we;
    assign conflict_cnt = r_conflict_cnt;
    assign o_state      = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed per-cycle vector table plus hand-written sequences
// for conflicts, counter saturation and reset during an in-flight store.
module tb_mem_arbiter;
    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] conflict_cnt;
    logic [1:0]  o_state;

    int n_vec  = 0;
    int n_fail = 0;

    // Expected grant order for conflict rounds: 1 = data, 0 = fetch.
    logic [0:0] exp_q[$];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt), .o_state(o_state)
    );

    // Clock / RAM model block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [15:0] ifa;
        logic        dr;
        logic        dwe;
        logic [15:0] da;
        logic [15:0] dwd;
        logic        e_ifack;
        logic [15:0] e_ifrd;
        logic        e_stall;
        logic        e_dack;
        logic [15:0] e_drd;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
        logic [1:0]  e_st;
    } vec_t;

    vec_t tbl [0:14];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = 16'h0000;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
    endtask

    // Driver: both ports request together; acks are checked against exp_q and
    // each port drops its request right after its ack.
    task automatic conflict_round(input int rnd);
        int n_ack = 0;
        int cyc = 0;
        int c_first = 0;
        int c_second = 0;
        logic [0:0] exp_g;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
`else
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
`endif
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0020;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
        while (n_ack < 2 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (d_ack || if_ack) begin
                exp_g = exp_q.pop_front();
                chk("grant_order", rnd, {15'd0, d_ack}, {15'd0, exp_g});
                if (d_ack)  chk("conf_d_rdata", rnd, d_rdata, 16'hA5A5);
                if (if_ack) chk("conf_if_rdata", rnd, if_rdata, 16'h5678);
                if (n_ack == 0) c_first = cyc; else c_second = cyc;
                n_ack++;
            end
            @(negedge clk);
            if (d_ack)  d_req  = 1'b0;
            if (if_ack) if_req = 1'b0;
        end
        if (n_ack < 2) begin
            n_vec++; n_fail++;
            $display("FAIL conflict_timeout [%0d]: acks seen %0d, expected 2", rnd, n_ack);
            exp_q.delete();
        end
        chk("first_ack_cycle", rnd, 16'(c_first), 16'd2);
        chk("second_ack_cycle", rnd, 16'(c_second), 16'd4);
        idle_inputs();
        @(posedge clk); #1;
        chk("conf_back_idle", rnd, {14'd0, o_state}, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        ram[16'h0010] = 16'h1234;
        ram[16'h0020] = 16'h5678;
        ram[16'h0030] = 16'hA5A5;
        ram[16'h0050] = 16'h0F0F;
        ram_rdata = 16'h0000;
        reset = 1'b1;
        idle_inputs();

        //             rst ifr ifa       dr dwe da        dwd      | ifack ifrd     stall dack drd      we addr      cnt      st
        tbl[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,2'd0};
        tbl[1]  = '{1'b0,1'b1,16'h0010,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0,16'h0010,16'h0000,2'd1};
        tbl[2]  = '{1'b0,1'b1,16'h0010,1'b0,1'b0,16'h0000,16'h0000, 1'b1,16'h1234,1'b0,1'b0,16'h0000,1'b0,16'h0010,16'h0000,2'd2};
        tbl[3]  = '{1'b0,1'b0,16'h0010,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h1234,1'b0,1'b0,16'h0000,1'b0,16'h0010,16'h0000,2'd0};
        tbl[4]  = '{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h00F0,16'hBEEF, 1'b0,16'h1234,1'b0,1'b0,16'h0000,1'b1,16'h00F0,16'h0000,2'd1};
        tbl[5]  = '{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h00F0,16'hBEEF, 1'b0,16'h1234,1'b0,1'b1,16'h0000,1'b0,16'h00F0,16'h0000,2'd2};
        tbl[6]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h1234,1'b0,1'b0,16'h0000,1'b0,16'h00F0,16'h0000,2'd0};
        tbl[7]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h00F0,16'h0000, 1'b0,16'h1234,1'b0,1'b0,16'h0000,1'b0,16'h00F0,16'h0000,2'd1};
        tbl[8]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h00F0,16'h0000, 1'b0,16'h1234,1'b0,1'b1,16'hBEEF,1'b0,16'h00F0,16'h0000,2'd2};
        tbl[9]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h1234,1'b0,1'b0,16'hBEEF,1'b0,16'h00F0,16'h0000,2'd0};
        tbl[10] = '{1'b0,1'b1,16'h0050,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h1234,1'b1,1'b0,16'hBEEF,1'b0,16'h0050,16'h0000,2'd1};
        tbl[11] = '{1'b0,1'b0,16'h0050,1'b0,1'b0,16'h0000,16'h0000, 1'b1,16'h0F0F,1'b0,1'b0,16'hBEEF,1'b0,16'h0050,16'h0000,2'd2};
        tbl[12] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0F0F,1'b0,1'b0,16'hBEEF,1'b0,16'h0050,16'h0000,2'd0};
        tbl[13] = '{1'b1,1'b1,16'h0010,1'b1,1'b1,16'h00F0,16'h1111, 1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0,16'h0000,16'h0000,2'd0};
        tbl[14] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,2'd0};

        repeat (2) @(posedge clk);

        // Table: one vector per clock, driven on negedge, checked 1 time unit after posedge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            reset   = tbl[i].rst;
            if_req  = tbl[i].ifr;
            if_addr = tbl[i].ifa;
            d_req   = tbl[i].dr;
            d_we    = tbl[i].dwe;
            d_addr  = tbl[i].da;
            d_wdata = tbl[i].dwd;
            @(posedge clk); #1;
            chk("if_ack",   i, {15'd0, if_ack},   {15'd0, tbl[i].e_ifack});
            chk("if_rdata", i, if_rdata,          tbl[i].e_ifrd);
            chk("if_stall", i, {15'd0, if_stall}, {15'd0, tbl[i].e_stall});
            chk("d_ack",    i, {15'd0, d_ack},    {15'd0, tbl[i].e_dack});
            chk("d_rdata",  i, d_rdata,           tbl[i].e_drd);
            chk("ram_we",   i, {15'd0, ram_we},   {15'd0, tbl[i].e_we});
            chk("ram_addr", i, ram_addr,          tbl[i].e_addr);
            chk("conflict_cnt", i, conflict_cnt,  tbl[i].e_cnt);
            chk("state",    i, {14'd0, o_state},  {14'd0, tbl[i].e_st});
        end

        // Conflict rounds: order and counter.
        conflict_round(0);
        chk("cnt_after_round0", 0, conflict_cnt, 16'h0001);
        conflict_round(1);
        chk("cnt_after_round1", 1, conflict_cnt, 16'h0002);

        // Saturation: preload the counter just below the top.
        @(negedge clk);
        dut.r_conflict_cnt = 16'hFFFE;
        conflict_round(2);
        chk("cnt_reach_max", 2, conflict_cnt, 16'hFFFF);
        conflict_round(3);
        chk("cnt_saturated", 3, conflict_cnt, 16'hFFFF);

        // Reset while a store sits in ACCESS.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1111;
        @(posedge clk); #1;
        chk("rst_pre_state", 0, {14'd0, o_state}, 16'd1);
        chk("rst_pre_we", 0, {15'd0, ram_we}, 16'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_state", 0, {14'd0, o_state}, 16'd0);
        chk("rst_we", 0, {15'd0, ram_we}, 16'd0);
        chk("rst_d_ack", 0, {15'd0, d_ack}, 16'd0);
        chk("rst_ram_addr", 0, ram_addr, 16'h0000);
        chk("rst_ram_wdata", 0, ram_wdata, 16'h0000);
        chk("rst_if_rdata", 0, if_rdata, 16'h0000);
        chk("rst_d_rdata", 0, d_rdata, 16'h0000);
        chk("rst_cnt", 0, conflict_cnt, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_ack", k, {14'd0, d_ack, if_ack}, 16'd0);
            chk("post_rst_idle", k, {14'd0, o_state}, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: if_req  in  1  instruction-fetch read request, held high until if_ack.
REQ-004 SHALL have port: if_addr  in  16  fetch word address, stable while if_req high.
REQ-005 SHALL have port: if_ack  out  1  one-cycle fetch completion pulse.
REQ-006 SHALL have port: if_rdata  out  16  fetch read data.
REQ-007 SHALL have port: if_stall  out  1  combinational if_req AND NOT if_ack.
REQ-008 SHALL have port: d_req  in  1  data-access request, held high until d_ack.
REQ-009 SHALL have port: d_we  in  1  1 = store, 0 = load; stable while d_req high.
REQ-010 SHALL have port: d_addr  in  16  data word address.
REQ-011 SHALL have port: d_wdata  in  16  store data.
REQ-012 SHALL have port: d_ack  out  1  one-cycle data completion pulse.
REQ-013 SHALL have port: d_rdata  out  16  load data.
REQ-014 SHALL have port: ram_addr  out  16  shared RAM address.
REQ-015 SHALL have port: ram_wdata  out  16  shared RAM write data.
REQ-016 SHALL have port: ram_we  out  1  shared RAM write enable.
REQ-017 SHALL have port: ram_rdata  in  16  shared RAM read data, valid the cycle after ram_addr is presented (1-cycle synchronous read).
REQ-018 SHALL have port: conflict_cnt  out  16  saturating count of arbitration decisions where both requests were pending.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP; one granted port (fetch or data) is registered per access.
REQ-020 SHALL, in IDLE with any request pending at a rising edge, register the arbitration winner and enter ACCESS; with no request, remain in IDLE.
REQ-021 SHALL, in ACCESS, drive ram_addr from the granted port's address, and drive ram_we = 1 with ram_wdata = d_wdata only for a data store; ram_we SHALL be 0 in every other state.
REQ-022 SHALL move ACCESS -> RESP unconditionally; in RESP, assert the granted port's ack for exactly that cycle.
REQ-023 SHALL present ram_rdata on the granted port's rdata during RESP for loads and fetches; each rdata output SHALL hold its last value until that port's next read ack; stores SHALL not change d_rdata.
REQ-024 SHALL, in RESP, ignore the request of the port being acked; if the other port is requesting, go directly to ACCESS for it, else go to IDLE; sustained throughput is one access per 2 cycles.
REQ-025 SHALL complete an access that has entered ACCESS even if its request drops; the ack SHALL still pulse.
REQ-026 SHALL, when both requests are pending at an arbitration decision, grant data (fixed priority) unless REQ-033 applies, and increment conflict_cnt, saturating at 16'hFFFF.
REQ-027 SHALL keep ram_addr at the last driven value outside ACCESS.

Reset
REQ-028 SHALL, on reset high at a rising edge, enter IDLE regardless of state, aborting any in-flight access with no ack generated.
REQ-029 SHALL reset if_ack = 0, d_ack = 0, ram_we = 0, ram_addr = 16'h0000, ram_wdata = 16'h0000, if_rdata = 16'h0000, d_rdata = 16'h0000, conflict_cnt = 16'h0000, last-grant = data.
REQ-030 SHALL ignore requests during the cycle reset is high.

Configuration
REQ-031 SHALL use the macro MEM_ARBITER_ROUND_ROBIN_EN.
REQ-032 SHALL, without the macro, use fixed data-over-fetch priority per REQ-026.
REQ-033 SHALL, with the macro defined, resolve simultaneous requests to the port not granted last; after reset the first conflict goes to fetch; single requests are unaffected and conflict_cnt behaves identically.

Verification
REQ-034 SHALL cover fetch-only: if_req=1, if_addr=16'h0010, RAM[0x10]=16'h1234 -> ACCESS next cycle, if_ack with if_rdata=16'h1234 two cycles after the request edge, if_stall=1 until then.
REQ-035 SHALL cover store then load: d_we=1, d_addr=16'h00F0, d_wdata=16'hBEEF -> ram_we high for exactly one cycle, d_ack; then load of 0x00F0 -> d_rdata=16'hBEEF.
REQ-036 SHALL cover conflict with the macro undefined: both requests in the same cycle -> data acked first, fetch acked 2 cycles later, conflict_cnt=1.
REQ-037 SHALL cover conflict with the macro defined: two successive simultaneous-request rounds -> grant order fetch, data, fetch, data; conflict_cnt=2.
REQ-038 SHALL cover reset mid-ACCESS on a store: no ack, ram_we=0 the next cycle, all outputs at reset values, state IDLE.
REQ-039 SHALL cover conflict_cnt saturation: start the counter at 16'hFFFF, then one further conflict -> conflict_cnt remains 16'hFFFF.
